// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding and
// default widths/limits used by instr_fetch and its wait timer.
package fetch_pkg;

  localparam int ADDR_W_DEF   = 16;
  localparam int DATA_W_DEF   = 16;
  localparam int MAX_WAIT_DEF = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    ERR  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/wait_timer.sv
// Saturating wait counter for the fetch stage. It counts cycles the memory
// leaves a request unanswered. expired_o looks one increment ahead: it is
// high in the cycle whose increment would bring the count to LIMIT. This lets
// the owner leave its waiting state right after the LIMIT-th idle cycle.
module wait_timer #(
  parameter int LIMIT = 15,
  parameter int CW    = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: clear has priority, otherwise count up and stick at LIMIT
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != CW'(LIMIT))) begin
      count_d = count_q + CW'(1);
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // The pending increment is the one that reaches the limit
  always_comb begin
    expired_o = inc_i && !clr_i && (count_q >= CW'(LIMIT - 1));
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage. It samples the PC, requests the word from
// instruction memory over a req/ready handshake, and holds the returned word
// in IRw until decode acknowledges it. IRw keeps its last value after an ack
// or a flush, because the branch logic upstream keeps reading IRw[11:0].
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] PCw,
  input  logic              fetch_en,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] IRw,
  output logic              ir_valid,
  input  logic              ir_ack,
  output logic              pc_inc,
  output logic              fetch_err
);

  fetch_state_e state_q;
  fetch_state_e state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] irWord_q;
  logic              irValid_q;
  logic              pcInc_q;

  logic loadAddr;
  logic acceptRsp;
  logic dropValid;
  logic tmrClr;
  logic tmrInc;
  logic tmrExpired;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state. A flush beats both a memory response and a decode ack.
  // ERR is left only through reset.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (fetch_en && !flush) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (flush) begin
          state_d = IDLE;
        end else if (mem_ready) begin
          state_d = HOLD;
        end else if (tmrExpired) begin
          state_d = ERR;
        end
      end
      HOLD: begin
        if (flush) begin
          state_d = IDLE;
        end else if (ir_ack) begin
          state_d = fetch_en ? REQ : IDLE;
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs and datapath strobes derived from the current state
  always_comb begin
    loadAddr  = ((state_q == IDLE) && fetch_en && !flush) ||
                ((state_q == HOLD) && ir_ack && fetch_en && !flush);
    acceptRsp = (state_q == REQ) && mem_ready && !flush;
    dropValid = (state_q == HOLD) && (flush || ir_ack);
    tmrInc    = (state_q == REQ) && !mem_ready;
    tmrClr    = loadAddr || mem_ready;
    mem_req   = (state_q == REQ);
    fetch_err = (state_q == ERR);
  end

  // Address, instruction register, valid flag and PC-advance pulse.
  // The address is only loaded when a new request starts, so it stays put
  // for the whole time mem_req is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q    <= '0;
      irWord_q  <= '0;
      irValid_q <= 1'b0;
      pcInc_q   <= 1'b0;
    end else begin
      pcInc_q <= acceptRsp;
      if (loadAddr) begin
        addr_q <= PCw;
      end
      if (acceptRsp) begin
        irWord_q  <= mem_rdata;
        irValid_q <= 1'b1;
      end else if (dropValid) begin
        irValid_q <= 1'b0;
      end
    end
  end

  wait_timer #(
    .LIMIT(MAX_WAIT)
  ) u_wait_timer (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (tmrClr),
    .inc_i    (tmrInc),
    .expired_o(tmrExpired)
  );

  assign mem_addr = addr_q;
  assign IRw      = irWord_q;
  assign ir_valid = irValid_q;
  assign pc_inc   = pcInc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch. Inputs change 1 ns after each rising edge
// and outputs are checked at that same point, so every check sees the state
// the DUT entered on the edge just taken.
module tb_instr_fetch;

  logic        clk;
  logic        reset;
  logic [15:0] PCw;
  logic        fetch_en;
  logic        flush;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ready;
  logic [15:0] mem_rdata;
  logic [15:0] IRw;
  logic        ir_valid;
  logic        ir_ack;
  logic        pc_inc;
  logic        fetch_err;

  int errorCount;
  int checkCount;
  int pcIncSeen;

  instr_fetch dut (
    .clk      (clk),
    .reset    (reset),
    .PCw      (PCw),
    .fetch_en (fetch_en),
    .flush    (flush),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .IRw      (IRw),
    .ir_valid (ir_valid),
    .ir_ack   (ir_ack),
    .pc_inc   (pc_inc),
    .fetch_err(fetch_err)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count pc_inc pulses between edges to confirm one pulse per accepted word
  always @(negedge clk) begin
    if (pc_inc === 1'b1) begin
      pcIncSeen <= pcIncSeen + 1;
    end
  end

  // Safety net so a stuck run still ends with a report
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] pc, input logic fe, input logic fl,
                               input logic rdy, input logic [15:0] rdata,
                               input logic ack);
    PCw       = pc;
    fetch_en  = fe;
    flush     = fl;
    mem_ready = rdy;
    mem_rdata = rdata;
    ir_ack    = ack;
  endtask

  initial begin
    errorCount = 0;
    checkCount = 0;
    pcIncSeen  = 0;
    reset      = 1'b1;
    applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    checkOutput("rst_mem_req",   {31'd0, mem_req},   32'd0);
    checkOutput("rst_mem_addr",  {16'd0, mem_addr},  32'd0);
    checkOutput("rst_IRw",       {16'd0, IRw},       32'd0);
    checkOutput("rst_ir_valid",  {31'd0, ir_valid},  32'd0);
    checkOutput("rst_pc_inc",    {31'd0, pc_inc},    32'd0);
    checkOutput("rst_fetch_err", {31'd0, fetch_err}, 32'd0);

    // Basic fetch from 0x0005, memory answers in the first request cycle
    applyStimulus(16'h0005, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    tick();
    checkOutput("t1_mem_req",  {31'd0, mem_req},  32'd1);
    checkOutput("t1_mem_addr", {16'd0, mem_addr}, 32'h0005);
    checkOutput("t1_valid_lo", {31'd0, ir_valid}, 32'd0);
    applyStimulus(16'h0005, 1'b0, 1'b0, 1'b1, 16'hFFC5, 1'b0);
    tick();
    checkOutput("t1_IRw",      {16'd0, IRw},      32'hFFC5);
    checkOutput("t1_ir_valid", {31'd0, ir_valid}, 32'd1);
    checkOutput("t1_pc_inc",   {31'd0, pc_inc},   32'd1);
    checkOutput("t1_req_lo",   {31'd0, mem_req},  32'd0);
    applyStimulus(16'h0005, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    tick();
    checkOutput("t1_pc_inc_1cyc", {31'd0, pc_inc},   32'd0);
    checkOutput("t1_hold_valid",  {31'd0, ir_valid}, 32'd1);
    applyStimulus(16'h0005, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
    tick();
    checkOutput("t1_ack_valid", {31'd0, ir_valid}, 32'd0);
    checkOutput("t1_ack_req",   {31'd0, mem_req},  32'd0);
    checkOutput("t1_IRw_kept",  {16'd0, IRw},      32'hFFC5);

    // Address stays frozen while PC moves and memory stalls three cycles
    applyStimulus(16'h0005, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    tick();
    applyStimulus(16'h0006, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("t2_req_%0d", i),  {31'd0, mem_req},  32'd1);
      checkOutput($sformatf("t2_addr_%0d", i), {16'd0, mem_addr}, 32'h0005);
      tick();
    end
    checkOutput("t2_addr_last", {16'd0, mem_addr}, 32'h0005);
    checkOutput("t2_valid_lo",  {31'd0, ir_valid}, 32'd0);
    applyStimulus(16'h0006, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b0);
    tick();
    checkOutput("t2_IRw",     {16'd0, IRw},      32'h1234);
    checkOutput("t2_valid",   {31'd0, ir_valid}, 32'd1);
    checkOutput("t2_pc_inc",  {31'd0, pc_inc},   32'd1);

    // Back-to-back: ack plus fetch_en in HOLD starts the next request at once
    applyStimulus(16'h0006, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
    tick();
    checkOutput("t3_valid_lo", {31'd0, ir_valid}, 32'd0);
    checkOutput("t3_req",      {31'd0, mem_req},  32'd1);
    checkOutput("t3_addr",     {16'd0, mem_addr}, 32'h0006);

    // Flush in the same cycle as the response discards the word
    applyStimulus(16'h0006, 1'b0, 1'b1, 1'b1, 16'h7777, 1'b0);
    tick();
    checkOutput("t4_IRw_kept", {16'd0, IRw},      32'h1234);
    checkOutput("t4_valid",    {31'd0, ir_valid}, 32'd0);
    checkOutput("t4_pc_inc",   {31'd0, pc_inc},   32'd0);
    checkOutput("t4_req_lo",   {31'd0, mem_req},  32'd0);
    applyStimulus(16'h0006, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    tick();
    checkOutput("t4_idle", {31'd0, mem_req}, 32'd0);

    // Flush beats ack and fetch_en while holding a word
    applyStimulus(16'h0007, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    tick();
    applyStimulus(16'h0007, 1'b0, 1'b0, 1'b1, 16'h0BEE, 1'b0);
    tick();
    checkOutput("t5_IRw", {16'd0, IRw}, 32'h0BEE);
    applyStimulus(16'h0008, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
    tick();
    checkOutput("t5_valid",   {31'd0, ir_valid}, 32'd0);
    checkOutput("t5_req_lo",  {31'd0, mem_req},  32'd0);
    checkOutput("t5_addr",    {16'd0, mem_addr}, 32'h0007);
    checkOutput("t5_IRw_kept", {16'd0, IRw},     32'h0BEE);

    // Timeout: fifteen unanswered request cycles then ERR
    applyStimulus(16'h0020, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    tick();
    applyStimulus(16'h0020, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    for (int i = 1; i < 15; i++) begin
      tick();
    end
    checkOutput("t6_req_c15", {31'd0, mem_req},   32'd1);
    checkOutput("t6_err_c15", {31'd0, fetch_err}, 32'd0);
    tick();
    checkOutput("t6_err",    {31'd0, fetch_err}, 32'd1);
    checkOutput("t6_req_lo", {31'd0, mem_req},   32'd0);
    applyStimulus(16'h0021, 1'b1, 1'b0, 1'b1, 16'h5555, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("t6_sticky_%0d", i), {31'd0, fetch_err}, 32'd1);
      checkOutput($sformatf("t6_noreq_%0d", i),  {31'd0, mem_req},   32'd0);
      checkOutput($sformatf("t6_noinc_%0d", i),  {31'd0, pc_inc},    32'd0);
    end
    applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("t6_err_clr", {31'd0, fetch_err}, 32'd0);

    // Reset in the middle of a request, then a fresh fetch
    applyStimulus(16'h0030, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    tick();
    checkOutput("t7_req", {31'd0, mem_req}, 32'd1);
    applyStimulus(16'h0030, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("t7_rst_req",   {31'd0, mem_req},  32'd0);
    checkOutput("t7_rst_addr",  {16'd0, mem_addr}, 32'd0);
    checkOutput("t7_rst_IRw",   {16'd0, IRw},      32'd0);
    checkOutput("t7_rst_valid", {31'd0, ir_valid}, 32'd0);
    applyStimulus(16'h0031, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    tick();
    checkOutput("t7_addr", {16'd0, mem_addr}, 32'h0031);
    applyStimulus(16'h0031, 1'b0, 1'b0, 1'b1, 16'hA5A5, 1'b0);
    tick();
    checkOutput("t7_IRw",   {16'd0, IRw},      32'hA5A5);
    checkOutput("t7_valid", {31'd0, ir_valid}, 32'd1);
    applyStimulus(16'h0031, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    tick();

    // Four words were accepted over the whole run
    checkOutput("pc_inc_total", pcIncSeen, 32'd4);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
